pong_game_sequencer: RTL and testbench

- Match-level controller for the Pong datapath. It sequences idle, serve, rally, point-pause and game-over phases.
- Gates the ball engine and paddle movement, and keeps both player scores.
- Raises ball speed level after a set number of paddle hits.
- Sits between the ball/paddle state machine (miss and hit events) and the score consumers: dot matrix, graphics and timer start.

---
 rtl/pong_game_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_pong_game_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pong_game_sequencer.sv
// Match-level sequencer for the Pong datapath: serve/rally/point/game-over phases,
// score keeping, ball speed levels and enables for the ball engine and paddles.
module pong_game_sequencer #(
    parameter int unsigned WIN_SCORE      = 32'd7,
    parameter int unsigned SERVE_FRAMES   = 32'd120,
    parameter int unsigned POINT_FRAMES   = 32'd60,
    parameter int unsigned HITS_PER_LEVEL = 32'd4,
    parameter int unsigned MAX_LEVEL      = 32'd3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       frame_tick,
    input  logic       miss_left,
    input  logic       miss_right,
    input  logic       paddle_hit,
    output logic [2:0] state,
    output logic       ball_en,
    output logic       paddle_en,
    output logic       ball_load,
    output logic       serve_dir,
    output logic [1:0] speed_lvl,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic [1:0] winner
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SERVE = 3'd1;
    localparam logic [2:0] PLAY  = 3'd2;
    localparam logic [2:0] POINT = 3'd3;
    localparam logic [2:0] OVER  = 3'd4;

    localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 32'd1);
    localparam logic [7:0] POINT_LAST = 8'(POINT_FRAMES - 32'd1);
    localparam logic [3:0] HIT_LAST   = 4'(HITS_PER_LEVEL - 32'd1);
    localparam logic [3:0] WIN_VAL    = 4'(WIN_SCORE);
    localparam logic [1:0] MAX_VAL    = 2'(MAX_LEVEL);

    logic       start_q_r;
    logic [7:0] frame_cnt_r;
    logic [3:0] hit_cnt_r;

    logic       start_rise_s;
    logic [2:0] state_s;
    logic       ball_load_s;
    logic       serve_dir_s;
    logic [1:0] speed_s;
    logic [3:0] score1_s;
    logic [3:0] score2_s;
    logic [1:0] winner_s;
    logic [7:0] frame_cnt_s;
    logic [3:0] hit_cnt_s;

    function automatic logic [3:0] score_inc(input logic [3:0] s);
        if (s < WIN_VAL) begin
            score_inc = s + 4'd1;
        end else begin
            score_inc = s;
        end
    endfunction

    assign start_rise_s = start & ~start_q_r;

    // Next-state and next-output decode; outputs are registered below from these values.
    always_comb begin
        state_s     = state;
        ball_load_s = 1'b0;
        serve_dir_s = serve_dir;
        speed_s     = speed_lvl;
        score1_s    = score1;
        score2_s    = score2;
        winner_s    = winner;
        frame_cnt_s = frame_cnt_r;
        hit_cnt_s   = hit_cnt_r;
        case (state)
            IDLE, OVER: begin
                if (start_rise_s) begin
                    state_s     = SERVE;
                    ball_load_s = 1'b1;
                    serve_dir_s = 1'b1;
                    speed_s     = 2'd0;
                    score1_s    = 4'd0;
                    score2_s    = 4'd0;
                    winner_s    = 2'b00;
                    hit_cnt_s   = 4'd0;
                end else begin
                    state_s = state;
                end
            end
            SERVE: begin
                if (frame_tick && (frame_cnt_r == SERVE_LAST)) begin
                    state_s = PLAY;
                end else if (frame_tick) begin
                    frame_cnt_s = frame_cnt_r + 8'd1;
                end else begin
                    frame_cnt_s = frame_cnt_r;
                end
            end
            PLAY: begin
                // Any miss takes priority over a same-cycle paddle hit.
                if (miss_left && miss_right) begin
                    state_s = POINT;
                end else if (miss_left) begin
                    state_s     = POINT;
                    score2_s    = score_inc(score2);
                    serve_dir_s = 1'b0;
                end else if (miss_right) begin
                    state_s     = POINT;
                    score1_s    = score_inc(score1);
                    serve_dir_s = 1'b1;
                end else if (paddle_hit && (hit_cnt_r >= HIT_LAST)) begin
                    hit_cnt_s = 4'd0;
                    if (speed_lvl < MAX_VAL) begin
                        speed_s = speed_lvl + 2'd1;
                    end else begin
                        speed_s = speed_lvl;
                    end
                end else if (paddle_hit) begin
                    hit_cnt_s = hit_cnt_r + 4'd1;
                end else begin
                    hit_cnt_s = hit_cnt_r;
                end
            end
            POINT: begin
                if (frame_tick && (frame_cnt_r == POINT_LAST)) begin
                    if (score1 == WIN_VAL) begin
                        state_s  = OVER;
                        winner_s = 2'b01;
                    end else if (score2 == WIN_VAL) begin
                        state_s  = OVER;
                        winner_s = 2'b10;
                    end else begin
                        state_s     = SERVE;
                        ball_load_s = 1'b1;
                        speed_s     = 2'd0;
                        hit_cnt_s   = 4'd0;
                    end
                end else if (frame_tick) begin
                    frame_cnt_s = frame_cnt_r + 8'd1;
                end else begin
                    frame_cnt_s = frame_cnt_r;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        if (state_s != state) begin
            frame_cnt_s = 8'd0;
        end else begin
            frame_cnt_s = frame_cnt_s;
        end
    end

    // State, counters and all Moore outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            ball_en     <= 1'b0;
            paddle_en   <= 1'b0;
            ball_load   <= 1'b0;
            serve_dir   <= 1'b1;
            speed_lvl   <= 2'd0;
            score1      <= 4'd0;
            score2      <= 4'd0;
            winner      <= 2'b00;
            start_q_r   <= 1'b0;
            frame_cnt_r <= 8'd0;
            hit_cnt_r   <= 4'd0;
        end else begin
            state       <= state_s;
            ball_en     <= (state_s == PLAY);
            paddle_en   <= (state_s == SERVE) || (state_s == PLAY) || (state_s == POINT);
            ball_load   <= ball_load_s;
            serve_dir   <= serve_dir_s;
            speed_lvl   <= speed_s;
            score1      <= score1_s;
            score2      <= score2_s;
            winner      <= winner_s;
            start_q_r   <= start;
            frame_cnt_r <= frame_cnt_s;
            hit_cnt_r   <= hit_cnt_s;
        end
    end

endmodule

// File: tb/tb_pong_game_sequencer.sv
// Self-checking bench for pong_game_sequencer: table vectors plus scripted match
// sequences; expected outputs go through a scoreboard queue.
module tb_pong_game_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       frame_tick = 1'b0;
    logic       miss_left = 1'b0;
    logic       miss_right = 1'b0;
    logic       paddle_hit = 1'b0;
    logic [2:0] state;
    logic       ball_en;
    logic       paddle_en;
    logic       ball_load;
    logic       serve_dir;
    logic [1:0] speed_lvl;
    logic [3:0] score1;
    logic [3:0] score2;
    logic [1:0] winner;

    typedef struct packed {
        logic [2:0] st;
        logic       be;
        logic       pe;
        logic       bl;
        logic       sd;
        logic [1:0] spd;
        logic [3:0] s1;
        logic [3:0] s2;
        logic [1:0] win;
    } exp_t;

    typedef struct packed {
        logic st;
        logic ft;
        logic ml;
        logic mr;
        logic ph;
    } in_t;

    typedef struct {
        in_t  in;
        exp_t e;
    } vec_t;

    exp_t exp_q[$];
    vec_t tbl[6];
    int   n_checks = 0;
    int   n_pass = 0;

    pong_game_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .frame_tick(frame_tick),
        .miss_left(miss_left), .miss_right(miss_right), .paddle_hit(paddle_hit),
        .state(state), .ball_en(ball_en), .paddle_en(paddle_en), .ball_load(ball_load),
        .serve_dir(serve_dir), .speed_lvl(speed_lvl), .score1(score1), .score2(score2),
        .winner(winner)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [2:0] st, input logic be, input logic pe,
                                input logic bl, input logic sd, input logic [1:0] spd,
                                input logic [3:0] s1, input logic [3:0] s2, input logic [1:0] win);
        exp_t e;
        e.st = st; e.be = be; e.pe = pe; e.bl = bl; e.sd = sd;
        e.spd = spd; e.s1 = s1; e.s2 = s2; e.win = win;
        return e;
    endfunction

    function automatic in_t mi(input logic st, input logic ft, input logic ml,
                               input logic mr, input logic ph);
        in_t i;
        i.st = st; i.ft = ft; i.ml = ml; i.mr = mr; i.ph = ph;
        return i;
    endfunction

    task automatic drive(input in_t i);
        start = i.st; frame_tick = i.ft; miss_left = i.ml; miss_right = i.mr; paddle_hit = i.ph;
    endtask

    task automatic compare(input string tag);
        exp_t a;
        exp_t e;
        a = {state, ball_en, paddle_en, ball_load, serve_dir, speed_lvl, score1, score2, winner};
        n_checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL %s: scoreboard empty, actual state=%0d", tag, state);
        end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
                $display("FAIL %s: actual st=%0d be=%b pe=%b bl=%b sd=%b spd=%0d s1=%0d s2=%0d win=%b, required st=%0d be=%b pe=%b bl=%b sd=%b spd=%0d s1=%0d s2=%0d win=%b",
                         tag, a.st, a.be, a.pe, a.bl, a.sd, a.spd, a.s1, a.s2, a.win,
                         e.st, e.be, e.pe, e.bl, e.sd, e.spd, e.s1, e.s2, e.win);
            end else begin
                n_pass++;
            end
        end
    endtask

    // Drive one cycle, push the expectation, sample #1 after the edge and compare.
    task automatic apply(input in_t i, input exp_t e, input string tag);
        drive(i);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        compare(tag);
    endtask

    task automatic step(input in_t i);
        drive(i);
        @(posedge clk);
        #1;
    endtask

    task automatic run_ticks(input int n, input logic st);
        for (int k = 0; k < n; k++) begin
            step(mi(st, 1'b1, 1'b0, 1'b0, 1'b0));
            step(mi(st, 1'b0, 1'b0, 1'b0, 1'b0));
        end
    endtask

    initial begin
        tbl[0] = '{mi(0, 0, 0, 0, 0), mk(0, 0, 0, 0, 1, 0, 0, 0, 0)};
        tbl[1] = '{mi(0, 1, 1, 0, 1), mk(0, 0, 0, 0, 1, 0, 0, 0, 0)};
        tbl[2] = '{mi(1, 0, 0, 0, 0), mk(1, 0, 1, 1, 1, 0, 0, 0, 0)};
        tbl[3] = '{mi(1, 0, 0, 0, 0), mk(1, 0, 1, 0, 1, 0, 0, 0, 0)};
        tbl[4] = '{mi(0, 0, 0, 1, 1), mk(1, 0, 1, 0, 1, 0, 0, 0, 0)};
        tbl[5] = '{mi(0, 1, 0, 0, 0), mk(1, 0, 1, 0, 1, 0, 0, 0, 0)};

        #12;
        exp_q.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
        compare("reset_values");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int v = 0; v < 6; v++) begin
            apply(tbl[v].in, tbl[v].e, $sformatf("vec%0d", v));
        end

        // One tick already counted by vec5; 118 more leaves SERVE one tick short.
        run_ticks(118, 1'b0);
        apply(mi(0, 0, 0, 0, 0), mk(1, 0, 1, 0, 1, 0, 0, 0, 0), "serve_119_ticks");
        apply(mi(0, 1, 0, 0, 0), mk(2, 1, 1, 0, 1, 0, 0, 0, 0), "serve_to_play");
        apply(mi(1, 1, 0, 0, 0), mk(2, 1, 1, 0, 1, 0, 0, 0, 0), "play_ignores_tick_start");

        for (int h = 1; h <= 3; h++) begin
            apply(mi(0, 0, 0, 0, 1), mk(2, 1, 1, 0, 1, 0, 0, 0, 0), $sformatf("pre_hit%0d", h));
        end
        apply(mi(0, 0, 1, 1, 1), mk(3, 0, 1, 0, 1, 0, 0, 0, 0), "double_miss_replay");
        run_ticks(59, 1'b0);
        apply(mi(0, 0, 0, 0, 0), mk(3, 0, 1, 0, 1, 0, 0, 0, 0), "point_59_ticks");
        apply(mi(0, 1, 0, 0, 0), mk(1, 0, 1, 1, 1, 0, 0, 0, 0), "point_to_serve");
        run_ticks(120, 1'b0);

        for (int h = 1; h <= 20; h++) begin
            logic [1:0] lvl;
            lvl = (h >= 12) ? 2'd3 : 2'(h / 4);
            apply(mi(0, 0, 0, 0, 1), mk(2, 1, 1, 0, 1, lvl, 0, 0, 0), $sformatf("hit%0d", h));
        end
        apply(mi(0, 0, 0, 1, 1), mk(3, 0, 1, 0, 1, 3, 1, 0, 0), "miss_right");
        run_ticks(60, 1'b0);
        apply(mi(0, 0, 0, 0, 0), mk(1, 0, 1, 0, 1, 0, 1, 0, 0), "serve_speed_cleared");
        run_ticks(120, 1'b0);

        for (int k = 1; k <= 7; k++) begin
            apply(mi(0, 0, 1, 0, 0), mk(3, 0, 1, 0, 0, 0, 1, 4'(k), 0), $sformatf("miss_left%0d", k));
            if (k < 7) begin
                run_ticks(59, 1'b0);
                apply(mi(0, 1, 0, 0, 0), mk(1, 0, 1, 1, 0, 0, 1, 4'(k), 0), $sformatf("reserve%0d", k));
                run_ticks(120, 1'b0);
            end
        end
        apply(mi(1, 0, 0, 0, 0), mk(3, 0, 1, 0, 0, 0, 1, 7, 0), "point_ignores_start");
        run_ticks(59, 1'b1);
        apply(mi(1, 1, 0, 0, 0), mk(4, 0, 0, 0, 0, 0, 1, 7, 2'b10), "game_over");
        apply(mi(1, 1, 1, 1, 1), mk(4, 0, 0, 0, 0, 0, 1, 7, 2'b10), "over_start_held");
        apply(mi(0, 0, 0, 0, 0), mk(4, 0, 0, 0, 0, 0, 1, 7, 2'b10), "over_start_low");
        apply(mi(1, 0, 0, 0, 0), mk(1, 0, 1, 1, 1, 0, 0, 0, 0), "restart");

        run_ticks(120, 1'b0);
        apply(mi(0, 0, 0, 1, 0), mk(3, 0, 1, 0, 1, 0, 1, 0, 0), "pre_reset_point");
        run_ticks(30, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        exp_q.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
        compare("async_reset");
        apply(mi(1, 1, 0, 0, 0), mk(0, 0, 0, 0, 1, 0, 0, 0, 0), "held_in_reset");
        drive(mi(0, 0, 0, 0, 0));
        rst = 1'b1;
        apply(mi(0, 0, 0, 0, 0), mk(0, 0, 0, 0, 1, 0, 0, 0, 0), "idle_after_reset");
        apply(mi(1, 0, 0, 0, 0), mk(1, 0, 1, 1, 1, 0, 0, 0, 0), "start_after_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
